alu_pipe: RTL and testbench

//   Parametrised, 2-stage pipelined successor to the 4-op add/sub/logic unit.
//   - Keeps ops ADD, SUB, NOTB and GTU; adds an internal accumulator with load/add/clear ops.
//   - Uses valid/ready handshakes on both sides.
//   - Sits between an operand producer and a result consumer; sustains 1 op/cycle.

---
 rtl/alu_pipe_pkg.sv | 24 ++
 rtl/alu_pipe_if.sv | 41 ++++
 rtl/alu_pipe_core.sv | 76 +++++++
 rtl/alu_pipe.sv | 113 +++++++++++
 tb/tb_alu_pipe.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared types for the alu_pipe block: opcode enum and flag bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_NOTB    = 3'd2,
    OP_GTU     = 3'd3,
    OP_ACC_ADD = 3'd4,
    OP_ACC_LD  = 3'd5,
    OP_ACC_CLR = 3'd6,
    OP_RSVD    = 3'd7
  } op_t;

  // flags bus is {N,Z,C,V}
  localparam int NUM_FLAGS = 4;
  localparam int FLAG_V    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_N    = 3;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe (flags only with ALU_PIPE_FLAGS_EN).
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the result side.
interface alu_pipe_if
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] acc;
`ifdef ALU_PIPE_FLAGS_EN
  logic [NUM_FLAGS-1:0] flags;
`endif

  // producer/consumer side
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, r, acc
`ifdef ALU_PIPE_FLAGS_EN
    , input flags
`endif
  );

  // ALU side
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, r, acc
`ifdef ALU_PIPE_FLAGS_EN
    , output flags
`endif
  );

endinterface

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: (op,a,b,acc) -> (r, acc_next, acc_we, flags with ALU_PIPE_FLAGS_EN).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when results and acc_next are committed.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] acc_next,
  output logic             acc_we
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic [NUM_FLAGS-1:0] flags
`endif
);

  // Result and accumulator update selection per opcode
  always_comb begin
    r        = '0;
    acc_next = acc;
    acc_we   = 1'b0;
    case (op)
      OP_ADD:     r = a + b;
      OP_SUB:     r = a - b;
      OP_NOTB:    r = ~b;
      OP_GTU:     r = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_ACC_ADD: begin
        acc_next = acc + a;
        acc_we   = 1'b1;
        r        = acc + a;
      end
      OP_ACC_LD:  begin
        acc_next = a;
        acc_we   = 1'b1;
        r        = a;
      end
      OP_ACC_CLR: begin
        acc_next = ACC_INIT;
        acc_we   = 1'b1;
        r        = ACC_INIT;
      end
      default:    r = '0;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  // Status flags; an unsigned sum wraps below an addend exactly when it carries out
  always_comb begin
    flags         = '0;
    flags[FLAG_N] = r[WIDTH-1];
    flags[FLAG_Z] = (r == '0);
    case (op)
      OP_ADD: begin
        flags[FLAG_C] = (r < a);
        flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        flags[FLAG_C] = (a < b);
        flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ACC_ADD: begin
        flags[FLAG_C] = (r < acc);
        flags[FLAG_V] = (acc[WIDTH-1] == a[WIDTH-1]) && (r[WIDTH-1] != acc[WIDTH-1]);
      end
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/alu_pipe.sv
// 2-stage pipelined ALU with internal accumulator; optional flags via ALU_PIPE_FLAGS_EN.
// Latency: result valid 2 clk edges after input acceptance; 1 op/cycle sustained.
// Backpressure: in_ready = !s1_valid || !s2_valid || out_ready; stalled outputs hold stable.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input logic        clk,
  input logic        rst_n,
  alu_pipe_if.slave  bus
);

  logic             s1_valid;
  op_t              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] core_r;
  logic [WIDTH-1:0] core_acc_next;
  logic             core_acc_we;
  logic             in_ready;
  logic             in_fire;
  logic             s2_adv;

  // S1 may refill whenever it is empty, draining into S2, or the whole pipe is moving
  assign in_ready = !s1_valid || !s2_valid || bus.out_ready;
  assign in_fire  = bus.in_valid && in_ready;
  assign s2_adv   = s1_valid && (!s2_valid || bus.out_ready);

`ifdef ALU_PIPE_FLAGS_EN
  logic [NUM_FLAGS-1:0] core_flags;
  logic [NUM_FLAGS-1:0] flags_q;
`endif

  alu_core #(
    .WIDTH    (WIDTH),
    .ACC_INIT (ACC_INIT)
  ) u_core (
    .op       (s1_op),
    .a        (s1_a),
    .b        (s1_b),
    .acc      (acc_q),
    .r        (core_r),
    .acc_next (core_acc_next),
    .acc_we   (core_acc_we)
`ifdef ALU_PIPE_FLAGS_EN
    ,
    .flags    (core_flags)
`endif
  );

  // S1: capture accepted op/a/b, free the slot when it moves on to S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_op    <= bus.op;
      s1_a     <= bus.a;
      s1_b     <= bus.b;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: register the computed result; hold while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      r_q      <= '0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      r_q      <= core_r;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Accumulator commits only on the S1->S2 move, so a stalled op never touches it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= ACC_INIT;
    end else if (s2_adv && core_acc_we) begin
      acc_q <= core_acc_next;
    end
  end

`ifdef ALU_PIPE_FLAGS_EN
  // Flags travel with r through S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (s2_adv) begin
      flags_q <= core_flags;
    end
  end

  assign bus.flags = flags_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.r         = r_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed table, hand-written sequences, random vs. reference model.
// Latency: drives at negedge, samples 1ns later; checks the 2-edge result latency.
// Backpressure: exercises out_ready stalls, in_ready drop and output hold.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W = 16;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W), .ACC_INIT(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
  } exp_t;

  typedef struct {
    op_t          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [3:0]   f;
  } vec_t;

  exp_t         exp_q[$];
  vec_t         vecs[14];
  int           tests = 0;
  int           fails = 0;
  bit           use_model = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_r;
  int unsigned  model_acc = 0;
  bit           inf, of;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic int sgn(int unsigned x);
    return (x >= M / 2) ? int'(x) - M : int'(x);
  endfunction

  // Reference: plain integer arithmetic on the op definitions
  function automatic exp_t model(op_t o, int unsigned av, int unsigned bv);
    exp_t e;
    int unsigned res = 0;
    bit c = 1'b0;
    bit v = 1'b0;
    int s;
    case (o)
      OP_ADD: begin
        res = (av + bv) % M; c = (av + bv) >= M;
        s = sgn(av) + sgn(bv); v = (s > M / 2 - 1) || (s < -(M / 2));
      end
      OP_SUB: begin
        res = (av + M - bv) % M; c = av < bv;
        s = sgn(av) - sgn(bv); v = (s > M / 2 - 1) || (s < -(M / 2));
      end
      OP_NOTB: res = M - 1 - bv;
      OP_GTU:  res = (av > bv) ? 1 : 0;
      OP_ACC_ADD: begin
        res = (model_acc + av) % M; c = (model_acc + av) >= M;
        s = sgn(model_acc) + sgn(av); v = (s > M / 2 - 1) || (s < -(M / 2));
        model_acc = res;
      end
      OP_ACC_LD:  begin res = av; model_acc = av; end
      OP_ACC_CLR: begin res = 0; model_acc = 0; end
      default:    res = 0;
    endcase
    e.r = res[W-1:0];
    e.f = {res >= M / 2, res == 0, c, v};
    return e;
  endfunction

  // One clock cycle: drive, sample, score any result handed over at the coming edge
  task automatic tick(input bit iv, input op_t o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input bit ordy, output bit in_f, output bit out_f);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.op        = o;
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = ordy;
    #1;
    if (prev_stall) begin
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_r", 32'(bus.r), 32'(prev_r));
    end
    in_f = iv && bus.in_ready;
    if (in_f && use_model) exp_q.push_back(model(o, 32'(av), 32'(bv)));
    out_f = bus.out_valid && ordy;
    if (out_f) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(bus.r), 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check("result_r", 32'(bus.r), 32'(e.r));
`ifdef ALU_PIPE_FLAGS_EN
        check("result_flags", 32'(bus.flags), 32'(e.f));
`endif
      end
    end
    prev_stall = bus.out_valid && !ordy;
    prev_r     = bus.r;
  endtask

  task automatic release_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int idx;
    vecs[0]  = '{OP_ADD,     16'd2,      16'd3,      16'd5,      4'b0000};
    vecs[1]  = '{OP_ADD,     16'hFFFF,   16'd1,      16'd0,      4'b0110};
    vecs[2]  = '{OP_ADD,     16'h7FFF,   16'd1,      16'h8000,   4'b1001};
    vecs[3]  = '{OP_SUB,     16'd100,    16'd200,    16'hFF9C,   4'b1010};
    vecs[4]  = '{OP_SUB,     16'd10,     16'd5,      16'd5,      4'b0000};
    vecs[5]  = '{OP_SUB,     16'h8000,   16'd1,      16'h7FFF,   4'b0001};
    vecs[6]  = '{OP_GTU,     16'd10,     16'd3,      16'd1,      4'b0000};
    vecs[7]  = '{OP_GTU,     16'd3,      16'd10,     16'd0,      4'b0100};
    vecs[8]  = '{OP_GTU,     16'd5,      16'd5,      16'd0,      4'b0100};
    vecs[9]  = '{OP_NOTB,    16'd0,      16'd7,      16'hFFF8,   4'b1000};
    vecs[10] = '{OP_ACC_LD,  16'd10,     16'd0,      16'd10,     4'b0000};
    vecs[11] = '{OP_ACC_ADD, 16'hFFF6,   16'd0,      16'd0,      4'b0110};
    vecs[12] = '{OP_ACC_CLR, 16'd77,     16'd0,      16'd0,      4'b0100};
    vecs[13] = '{OP_RSVD,    16'd5,      16'd5,      16'd0,      4'b0100};

    // Reset state, with in_valid asserted to show it is ignored
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.op = OP_ACC_LD; bus.a = 16'h1234; bus.b = '0; bus.out_ready = 1'b1;
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_r", 32'(bus.r), 32'd0);
    check("reset_acc", 32'(bus.acc), 32'd0);
`ifdef ALU_PIPE_FLAGS_EN
    check("reset_flags", 32'(bus.flags), 32'd0);
`endif
    repeat (3) @(posedge clk);
    release_reset();

    // Directed table, one op at a time, with latency measurement
    use_model = 1'b0;
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back('{vecs[i].r, vecs[i].f});
      tick(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, inf, of);
      check("vec_accept", 32'(inf), 32'd1);
      n = 0; of = 1'b0;
      while (!of && n < 8) begin
        tick(1'b0, OP_ADD, '0, '0, 1'b1, inf, of);
        n++;
      end
      check("vec_latency", 32'(n), 32'd2);
      exp_q.delete();
    end
    check("table_acc", 32'(bus.acc), 32'd0);

    // Back-to-back accumulator chain
    exp_q.push_back('{16'd10, 4'b0000});
    exp_q.push_back('{16'd15, 4'b0000});
    exp_q.push_back('{16'd20, 4'b0000});
    exp_q.push_back('{16'd25, 4'b0000});
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, (i == 0) ? OP_ACC_LD : OP_ACC_ADD, (i == 0) ? 16'd10 : 16'd5, '0, 1'b1, inf, of);
      check("chain_accept", 32'(inf), 32'd1);
    end
    repeat (4) tick(1'b0, OP_ADD, '0, '0, 1'b1, inf, of);
    check("chain_drained", 32'(exp_q.size()), 32'd0);
    check("chain_acc", 32'(bus.acc), 32'd25);

    // Backpressure: out_ready low for 3 cycles while issuing 4 ADDs
    for (int i = 1; i <= 4; i++) exp_q.push_back('{W'(2 * i), 4'b0000});
    idx = 0;
    for (int c = 0; c < 20 && (idx < 4 || exp_q.size() > 0); c++) begin
      tick(idx < 4, OP_ADD, W'(idx + 1), W'(idx + 1), c >= 3, inf, of);
      if (inf) idx++;
      if (c == 2) begin
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_two_accepted", 32'(idx), 32'd2);
        check("bp_stalled_r", 32'(bus.r), 32'd2);
      end
    end
    check("bp_all_issued", 32'(idx), 32'd4);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Mid-stream reset with acc=25 and two ops in flight
    exp_q.push_back('{16'd25, 4'b0000});
    tick(1'b1, OP_ACC_LD, 16'd25, '0, 1'b1, inf, of);
    repeat (3) tick(1'b0, OP_ADD, '0, '0, 1'b1, inf, of);
    check("pre_reset_acc", 32'(bus.acc), 32'd25);
    tick(1'b1, OP_ACC_ADD, 16'd1, '0, 1'b0, inf, of);
    tick(1'b1, OP_ACC_ADD, 16'd2, '0, 1'b0, inf, of);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset_acc", 32'(bus.acc), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    exp_q.push_back('{16'd3, 4'b0000});
    tick(1'b1, OP_ACC_ADD, 16'd3, '0, 1'b1, inf, of);
    n = 0; of = 1'b0;
    while (!of && n < 8) begin
      tick(1'b0, OP_ADD, '0, '0, 1'b1, inf, of);
      n++;
    end
    check("post_reset_acc_add_seen", 32'(of), 32'd1);
    check("post_reset_acc", 32'(bus.acc), 32'd3);

    // Randomised stream against the reference model
    model_acc = 3;
    use_model = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
      tick($urandom_range(0, 3) != 0, op_t'($urandom_range(0, 7)), ra, rb,
           $urandom_range(0, 9) < 7, inf, of);
    end
    repeat (6) tick(1'b0, OP_ADD, '0, '0, 1'b1, inf, of);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_acc", 32'(bus.acc), 32'(model_acc));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
